// File: rtl/toy_bus_pkg.sv
// Shared ToyBus payload widths, the ToyBusAck beat struct and the round-robin pointer helper.
package toy_bus_pkg;

    localparam int OPCODE_W   = 1;
    localparam int DATA_W     = 256;
    localparam int SIDEBAND_W = 10;
    localparam int ID_W       = 4;
    localparam int GRANT_W    = 3;
    localparam int PERF_W     = 16;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [DATA_W-1:0]     data;
        logic [SIDEBAND_W-1:0] sideband;
        logic [ID_W-1:0]       src_id;
        logic [ID_W-1:0]       tgt_id;
    } toy_bus_ack_t;

    // Pointer moves one past the winner, wrapping from n-1 back to 0.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/toy_bus_rr_pick.sv
// Combinational round-robin winner search: first asserted request at or above ptr, wrapping.
module toy_bus_rr_pick
    import toy_bus_pkg::*;
#(
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN-1:0]  req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] winner,
    output logic               any_req
);

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        // Outer loop walks the search order from ptr; first hit wins.
        for (int k = 0; k < NUM_IN; k++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (!any_req && req[j] && (j == ((int'(ptr) + k) % NUM_IN))) begin
                    winner  = GRANT_W'(j);
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/toy_bus_arb_node_rr.sv
// Round-robin merge of NUM_IN single-beat ToyBusAck requesters into one registered output.
// Optional per-requester grant counters are built when TOY_BUS_ARB_PERF_CNT_EN is defined.
module toy_bus_arb_node_rr
    import toy_bus_pkg::*;
#(
    parameter int NUM_IN = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_vld,
    output logic [NUM_IN-1:0]            in_rdy,
    input  logic [NUM_IN*OPCODE_W-1:0]   in_opcode,
    input  logic [NUM_IN*DATA_W-1:0]     in_data,
    input  logic [NUM_IN*SIDEBAND_W-1:0] in_sideband,
    input  logic [NUM_IN*ID_W-1:0]       in_src_id,
    input  logic [NUM_IN*ID_W-1:0]       in_tgt_id,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [OPCODE_W-1:0]          out_opcode,
    output logic [DATA_W-1:0]            out_data,
    output logic [SIDEBAND_W-1:0]        out_sideband,
    output logic [ID_W-1:0]              out_src_id,
    output logic [ID_W-1:0]              out_tgt_id,
    output logic [GRANT_W-1:0]           out_grant_id
`ifdef TOY_BUS_ARB_PERF_CNT_EN
    ,
    output logic [NUM_IN*PERF_W-1:0]     perf_grant_cnt
`endif
);

    logic               r_out_vld;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] r_grant_id;
    toy_bus_ack_t       r_out;

    logic [GRANT_W-1:0] w_winner;
    logic               w_any_req;
    logic               w_load_en;
    logic               w_accept;
    toy_bus_ack_t       w_pick;

    toy_bus_rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req     (in_vld),
        .ptr     (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_load_en = !r_out_vld || out_rdy;
    // Gating with rst_n keeps every in_rdy low while reset is applied.
    assign w_accept  = w_any_req && w_load_en && rst_n;

    always_comb begin
        in_rdy = '0;
        w_pick = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_winner == GRANT_W'(i)) begin
                in_rdy[i]       = w_accept;
                w_pick.opcode   = in_opcode[i*OPCODE_W +: OPCODE_W];
                w_pick.data     = in_data[i*DATA_W +: DATA_W];
                w_pick.sideband = in_sideband[i*SIDEBAND_W +: SIDEBAND_W];
                w_pick.src_id   = in_src_id[i*ID_W +: ID_W];
                w_pick.tgt_id   = in_tgt_id[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_out      <= '0;
        end else begin
            if (w_load_en) begin
                r_out_vld <= w_accept;
            end
            if (w_accept) begin
                r_out      <= w_pick;
                r_grant_id <= w_winner;
                r_rr_ptr   <= rr_next(w_winner, NUM_IN);
            end
        end
    end

    assign out_vld      = r_out_vld;
    assign out_opcode   = r_out.opcode;
    assign out_data     = r_out.data;
    assign out_sideband = r_out.sideband;
    assign out_src_id   = r_out.src_id;
    assign out_tgt_id   = r_out.tgt_id;
    assign out_grant_id = r_grant_id;

`ifdef TOY_BUS_ARB_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_cnt [NUM_IN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_perf_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_accept && (w_winner == GRANT_W'(i))) begin
                    r_perf_cnt[i] <= r_perf_cnt[i] + PERF_W'(1);
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            perf_grant_cnt[i*PERF_W +: PERF_W] = r_perf_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_toy_bus_arb_node_rr.sv
// Directed bench for toy_bus_arb_node_rr (NUM_IN=2) with a transaction-level reference model.
// Counter checks are included when TOY_BUS_ARB_PERF_CNT_EN is defined.
module tb_toy_bus_arb_node_rr;
    import toy_bus_pkg::*;

    localparam int N = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N-1:0]             in_vld;
    logic [N-1:0]             in_rdy;
    logic [N*OPCODE_W-1:0]    in_opcode;
    logic [N*DATA_W-1:0]      in_data;
    logic [N*SIDEBAND_W-1:0]  in_sideband;
    logic [N*ID_W-1:0]        in_src_id;
    logic [N*ID_W-1:0]        in_tgt_id;
    logic                     out_vld;
    logic                     out_rdy;
    logic [OPCODE_W-1:0]      out_opcode;
    logic [DATA_W-1:0]        out_data;
    logic [SIDEBAND_W-1:0]    out_sideband;
    logic [ID_W-1:0]          out_src_id;
    logic [ID_W-1:0]          out_tgt_id;
    logic [GRANT_W-1:0]       out_grant_id;
`ifdef TOY_BUS_ARB_PERF_CNT_EN
    logic [N*PERF_W-1:0]      perf_grant_cnt;
`endif

    toy_bus_arb_node_rr #(.NUM_IN(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_opcode    (in_opcode),
        .in_data      (in_data),
        .in_sideband  (in_sideband),
        .in_src_id    (in_src_id),
        .in_tgt_id    (in_tgt_id),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_opcode   (out_opcode),
        .out_data     (out_data),
        .out_sideband (out_sideband),
        .out_src_id   (out_src_id),
        .out_tgt_id   (out_tgt_id),
        .out_grant_id (out_grant_id)
`ifdef TOY_BUS_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the output slot as a single held beat plus a pointer.
    bit           m_vld = 1'b0;
    int           m_ptr = 0;
    int           m_grant = 0;
    logic [274:0] m_beat = '0;
    int           m_cnt [N] = '{default: 0};

    function automatic int find_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [274:0] beat_of(input int i);
        return {in_opcode[i*OPCODE_W +: OPCODE_W], in_data[i*DATA_W +: DATA_W],
                in_sideband[i*SIDEBAND_W +: SIDEBAND_W], in_src_id[i*ID_W +: ID_W],
                in_tgt_id[i*ID_W +: ID_W]};
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        int w;
        logic [N-1:0] r;
        r = '0;
        w = find_winner(in_vld, m_ptr);
        if (rst_n && w >= 0 && (!m_vld || out_rdy)) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_vld = 1'b0; m_ptr = 0; m_grant = 0; m_beat = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (!m_vld || out_rdy) begin
            w = find_winner(in_vld, m_ptr);
            if (w >= 0) begin
                m_beat  = beat_of(w);
                m_grant = w;
                m_ptr   = (w + 1) % N;
                m_vld   = 1'b1;
                m_cnt[w] = (m_cnt[w] + 1) % 65536;
            end else begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_rdy", 300'(in_rdy), 300'(exp_rdy()));
            check("out_vld", 300'(out_vld), 300'(m_vld));
            check("out_grant_id", 300'(out_grant_id), 300'(m_grant));
            check("payload", 300'({out_opcode, out_data, out_sideband, out_src_id, out_tgt_id}),
                  300'(m_beat));
`ifdef TOY_BUS_ARB_PERF_CNT_EN
            check("perf_grant_cnt", 300'(perf_grant_cnt),
                  300'({m_cnt[1][15:0], m_cnt[0][15:0]}));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int i, input logic [31:0] tag);
        in_opcode[i]                       = tag[0];
        in_data[i*DATA_W +: DATA_W]        = {8{tag}};
        in_sideband[i*SIDEBAND_W +: SIDEBAND_W] = tag[9:0];
        in_src_id[i*ID_W +: ID_W]          = 4'(i + 3);
        in_tgt_id[i*ID_W +: ID_W]          = tag[7:4];
    endtask

    initial begin
        rst_n = 1'b0; out_rdy = 1'b1; in_vld = 2'b11;
        in_opcode = '0; in_data = '0; in_sideband = '0; in_src_id = '0; in_tgt_id = '0;
        set_pl(0, 32'hA0A0_0000);
        set_pl(1, 32'hA0A0_0001);

        // Reset with both requesters valid.
        tick();
        chk_en = 1'b1;
        tick(); tick();
        #1;
        check("rst_in_rdy", 300'(in_rdy), 300'(2'b00));
        check("rst_out_vld", 300'(out_vld), 300'(1'b0));
        tick();
        rst_n = 1'b1;
        #1;
        check("first_grant_rdy", 300'(in_rdy), 300'(2'b01));

        // Rotation 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("rot_vld", 300'(out_vld), 300'(1'b1));
            check("rot_grant", 300'(out_grant_id), 300'(k % 2));
            check("rot_data", 300'(out_data[31:0]), 300'((k % 2 == 0) ? 32'hA0A0_0000 : 32'hA0A0_0001));
        end

        // Backpressure: beat from requester 1 held for 3 cycles.
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check("bp_vld", 300'(out_vld), 300'(1'b1));
            check("bp_grant", 300'(out_grant_id), 300'(1));
            check("bp_data", 300'(out_data[31:0]), 300'(32'hA0A0_0001));
            check("bp_rdy", 300'(in_rdy), 300'(2'b00));
        end
        out_rdy = 1'b1;
        tick(); #1;
        check("bp_resume_vld", 300'(out_vld), 300'(1'b1));
        check("bp_resume_grant", 300'(out_grant_id), 300'(0));

        // No requesters: slot empties next cycle.
        in_vld = 2'b00;
        tick(); #1;
        check("empty_vld", 300'(out_vld), 300'(1'b0));

        // Single requester 1: first moves ptr to 0, then the wrap case from ptr 0.
        in_vld = 2'b10;
        tick(); #1;
        check("single_grant_a", 300'(out_grant_id), 300'(1));
        tick(); #1;
        check("single_grant_b", 300'(out_grant_id), 300'(1));
        check("single_src", 300'(out_src_id), 300'(4'd4));
        in_vld = 2'b11;
        tick(); #1;
        check("wrap_ptr_grant", 300'(out_grant_id), 300'(0));

        // Reset mid-operation while a beat is held.
        out_rdy = 1'b0;
        tick();
        rst_n = 1'b0;
        tick(); #1;
        check("midrst_vld", 300'(out_vld), 300'(1'b0));
        check("midrst_grant", 300'(out_grant_id), 300'(0));
        rst_n = 1'b1; in_vld = 2'b00; out_rdy = 1'b1;
        tick(); #1;
        check("midrst_discard", 300'(out_vld), 300'(1'b0));

        // Mixed traffic with per-beat payloads; the compare process checks each cycle.
        for (int k = 0; k < 80; k++) begin
            in_vld  = 2'($urandom_range(0, 3));
            out_rdy = ($urandom_range(0, 9) < 7);
            set_pl(0, $urandom);
            set_pl(1, $urandom);
            tick();
        end

        // Drain: one beat then idle.
        in_vld = 2'b00; out_rdy = 1'b1;
        tick(); tick();
        set_pl(0, 32'h0000_5A5A);
        in_vld = 2'b01;
        tick(); #1;
        in_vld = 2'b00;
        check("drain_vld_1", 300'(out_vld), 300'(1'b1));
        check("drain_data", 300'(out_data[31:0]), 300'(32'h0000_5A5A));
        tick(); #1;
        check("drain_vld_0", 300'(out_vld), 300'(1'b0));
        tick(); #1;
        check("drain_vld_0b", 300'(out_vld), 300'(1'b0));

`ifdef TOY_BUS_ARB_PERF_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_vld = 2'b10; out_rdy = 1'b1;
        tick(); tick(); tick();
        in_vld = 2'b01;
        repeat (65535) tick();
        #1;
        check("cnt0_full", 300'(perf_grant_cnt[15:0]), 300'(16'hFFFF));
        tick(); #1;
        check("cnt0_wrap", 300'(perf_grant_cnt[15:0]), 300'(16'h0000));
        check("cnt1_kept", 300'(perf_grant_cnt[31:16]), 300'(16'd3));
        in_vld = 2'b00;
        tick();
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
